// File: rtl/slc3_mem_sequencer.sv
// SLC-3 memory sequencer: level-held Mem_OE/Mem_WE to timed async SRAM cycles.
// Define MEM_MMIO_EN to decode MAR=16'hFFFF as switches (read) / hex display (write).
module slc3_mem_sequencer #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int ADDR_W  = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR,
  output logic [15:0]       Data_to_CPU,
  output logic              Mem_Ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  input  logic [15:0]       SRAM_Din,
  output logic [15:0]       SRAM_Dout,
  output logic              SRAM_Drive,
  input  logic [15:0]       Switches,
  output logic [15:0]       HEX_Data
);

  if (RD_WAIT < 1 || RD_WAIT > 15 || WR_WAIT < 1 ||
      WR_WAIT > 15 || ADDR_W < 16) begin : g_bad_param
    $error("slc3_mem_sequencer: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_ACC, WR_HOLD, RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_q, data_d;
  logic [15:0] hex_q, hex_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        be_n_q, be_n_d;
  logic        drive_q, drive_d;
  logic        ready_q, ready_d;
  logic        mmio_hit;
  logic [15:0] sw_sync;

`ifdef MEM_MMIO_EN
  logic [15:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign mmio_hit = (MAR == 16'hFFFF);
  assign sw_sync  = sw_sync_q;
`else
  logic unused_sw;
  assign unused_sw = ^Switches;
  assign mmio_hit  = 1'b0;
  assign sw_sync   = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    hex_d   = hex_q;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = 1'b1;
    drive_d = 1'b0;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Mem_WE) begin
          addr_d  = MAR;
          wdata_d = MDR;
          if (mmio_hit) begin
            hex_d   = MDR;
            ready_d = 1'b1;
            state_d = RD_DONE;
          end else begin
            ce_n_d  = 1'b0;
            be_n_d  = 1'b0;
            drive_d = 1'b1;
            state_d = WR_SETUP;
          end
        end else if (Mem_OE) begin
          addr_d = MAR;
          if (mmio_hit) begin
            data_d  = sw_sync;
            ready_d = 1'b1;
            state_d = RD_DONE;
          end else begin
            ce_n_d  = 1'b0;
            oe_n_d  = 1'b0;
            be_n_d  = 1'b0;
            cnt_d   = 4'(RD_WAIT - 1);
            state_d = RD_ACC;
          end
        end
      end
      RD_ACC: begin
        if (cnt_q == 4'd0) begin
          data_d  = SRAM_Din;
          ready_d = 1'b1;
          state_d = RD_DONE;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
          be_n_d = 1'b0;
        end
      end
      RD_DONE: state_d = RELEASE;
      WR_SETUP: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        be_n_d  = 1'b0;
        drive_d = 1'b1;
        cnt_d   = 4'(WR_WAIT - 1);
        state_d = WR_ACC;
      end
      WR_ACC: begin
        ce_n_d  = 1'b0;
        be_n_d  = 1'b0;
        drive_d = 1'b1;
        if (cnt_q == 4'd0) begin
          ready_d = 1'b1;
          state_d = WR_HOLD;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = 1'b0;
        end
      end
      WR_HOLD: state_d = RELEASE;
      RELEASE: begin
        // a held strobe must drop before another access is accepted
        if (!Mem_OE && !Mem_WE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      hex_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 1'b1;
      drive_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      hex_q   <= hex_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      drive_q <= drive_d;
      ready_q <= ready_d;
    end
  end

  assign Data_to_CPU = data_q;
  assign Mem_Ready   = ready_q;
  assign SRAM_ADDR   = ADDR_W'(addr_q);
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = be_n_q;
  assign SRAM_LB_N   = be_n_q;
  assign SRAM_Dout   = wdata_q;
  assign SRAM_Drive  = drive_q;
  assign HEX_Data    = hex_q;

endmodule

// File: tb/tb_slc3_mem_sequencer.sv
// Randomized bench for slc3_mem_sequencer against an abstract memory model
// (expected latency RD_WAIT+1 / WR_WAIT+2, one access per strobe assertion).
module tb_slc3_mem_sequencer;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  localparam int ADDR_W  = 20;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Mem_OE, Mem_WE;
  logic [15:0]       MAR, MDR;
  logic [15:0]       Data_to_CPU;
  logic              Mem_Ready;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic              SRAM_UB_N, SRAM_LB_N;
  logic [15:0]       SRAM_Din, SRAM_Dout;
  logic              SRAM_Drive;
  logic [15:0]       Switches;
  logic [15:0]       HEX_Data;

  int errors = 0;
  int checks = 0;

  logic [15:0] sram [int];
  logic [15:0] exp_mem [int];

  slc3_mem_sequencer #(
    .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .Data_to_CPU(Data_to_CPU),
    .Mem_Ready(Mem_Ready), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_Din(SRAM_Din),
    .SRAM_Dout(SRAM_Dout), .SRAM_Drive(SRAM_Drive),
    .Switches(Switches), .HEX_Data(HEX_Data)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  // asynchronous SRAM pin model, evaluated mid-cycle
  always @(negedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N)
      sram[int'(SRAM_ADDR[15:0])] = SRAM_Dout;
    if (!SRAM_CE_N && !SRAM_OE_N)
      SRAM_Din = sram.exists(int'(SRAM_ADDR[15:0])) ?
                 sram[int'(SRAM_ADDR[15:0])] : init_val(SRAM_ADDR[15:0]);
    else
      SRAM_Din = 16'h0BAD;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : init_val(a);
  endfunction

  // called at a negedge with the DUT idle; leaves at a negedge
  task automatic run_access(input bit wr, input bit rd,
                            input logic [15:0] a, input logic [15:0] d,
                            input int extra);
    int lat, rdy_cyc, rdy_n, oe_lo, we_lo, drv, span;
    logic [15:0] exp_d;
    lat = wr ? WR_WAIT + 2 : RD_WAIT + 1;
    exp_d = wr ? d : model_rd(a);
    rdy_cyc = 0; rdy_n = 0; oe_lo = 0; we_lo = 0; drv = 0;
    Mem_WE = wr; Mem_OE = rd; MAR = a; MDR = d;
    span = lat + 1 + extra;
    for (int c = 1; c <= span; c++) begin
      @(posedge Clk); #1;
      if (c == 1) begin
        check("addr_latched", 32'(SRAM_ADDR), 32'(a));
        MAR = 16'($urandom);
        MDR = 16'($urandom);
      end
      if (!SRAM_OE_N && !SRAM_CE_N) oe_lo++;
      if (!SRAM_WE_N && !SRAM_CE_N) we_lo++;
      if (SRAM_Drive) drv++;
      if (Mem_Ready) begin
        rdy_n++;
        if (rdy_cyc == 0) rdy_cyc = c;
      end
      check("oe_we_excl", 32'(!SRAM_OE_N && !SRAM_WE_N), 0);
      check("drive_vs_oe", 32'(SRAM_Drive && !SRAM_OE_N), 0);
    end
    check("ready_cycle", 32'(rdy_cyc), 32'(lat));
    check("ready_pulses", 32'(rdy_n), 1);
    check("oe_low_cycles", 32'(oe_lo), wr ? 0 : 32'(RD_WAIT));
    check("we_low_cycles", 32'(we_lo), wr ? 32'(WR_WAIT) : 0);
    check("drive_cycles", 32'(drv), wr ? 32'(WR_WAIT + 2) : 0);
    if (wr) exp_mem[int'(a)] = d;
    else check("read_data", 32'(Data_to_CPU), 32'(exp_d));
    Mem_WE = 1'b0; Mem_OE = 1'b0;
    @(posedge Clk); #1;
    check("idle_no_ready", 32'(Mem_Ready), 0);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
    MAR = '0; MDR = '0; Switches = 16'h00A5;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
                          SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("rst_drive", 32'(SRAM_Drive), 0);
    check("rst_ready", 32'(Mem_Ready), 0);
    check("rst_data", 32'(Data_to_CPU), 0);
    check("rst_hex", 32'(HEX_Data), 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    run_access(1'b1, 1'b0, 16'h3000, 16'h1234, 0);
    run_access(1'b0, 1'b1, 16'h3000, 16'h0, 5 - (RD_WAIT + 2));
    run_access(1'b1, 1'b0, 16'h0040, 16'hBEEF, 1);
    run_access(1'b0, 1'b1, 16'h0040, 16'h0, 0);
    run_access(1'b1, 1'b1, 16'h0001, 16'h5A5A, 0);
    run_access(1'b0, 1'b1, 16'h0001, 16'h0, 0);
    run_access(1'b0, 1'b1, 16'h0010, 16'h0, 2);
    run_access(1'b0, 1'b1, 16'h0011, 16'h0, 2);

    // reset in the middle of a read access
    Mem_OE = 1'b1; MAR = 16'h3000;
    @(posedge Clk); #1;
    check("mid_rd_oe", 32'(SRAM_OE_N), 0);
    Reset = 1'b1; #1;
    check("mid_rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
                              SRAM_UB_N, SRAM_LB_N}, 5'b11111);
    check("mid_rst_drive", 32'(SRAM_Drive), 0);
    @(negedge Clk);
    Mem_OE = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    begin
      int rdy_seen;
      rdy_seen = 0;
      repeat (6) begin
        @(posedge Clk); #1;
        if (Mem_Ready) rdy_seen++;
      end
      check("mid_rst_no_ready", 32'(rdy_seen), 0);
      check("mid_rst_data", 32'(Data_to_CPU), 0);
    end
    @(negedge Clk);
    run_access(1'b0, 1'b1, 16'h0040, 16'h0, 0);

    for (int i = 0; i < 40; i++) begin
      bit wr, rd;
      int kind;
      kind = $urandom_range(0, 2);
      wr = (kind != 0);
      rd = (kind != 1);
      run_access(wr, rd, 16'($urandom_range(0, 31)),
                 16'($urandom), $urandom_range(0, 3));
    end

`ifdef MEM_MMIO_EN
    begin
      int rc;
      Mem_OE = 1'b1; MAR = 16'hFFFF;
      rc = 0;
      for (int c = 1; c <= 3; c++) begin
        @(posedge Clk); #1;
        if (Mem_Ready && rc == 0) rc = c;
        check("mmio_ce", 32'(SRAM_CE_N), 1);
      end
      check("mmio_rd_cycle", 32'(rc), 1);
      check("mmio_rd_data", 32'(Data_to_CPU), 32'h00A5);
      Mem_OE = 1'b0;
      @(posedge Clk); @(negedge Clk);
      Mem_WE = 1'b1; MAR = 16'hFFFF; MDR = 16'h0F0F;
      rc = 0;
      for (int c = 1; c <= 3; c++) begin
        @(posedge Clk); #1;
        if (Mem_Ready && rc == 0) rc = c;
        check("mmio_wr_ce", 32'(SRAM_CE_N), 1);
      end
      check("mmio_wr_cycle", 32'(rc), 1);
      check("mmio_hex", 32'(HEX_Data), 32'h0F0F);
      Mem_WE = 1'b0;
      @(posedge Clk); @(negedge Clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slc3_mem_sequencer.md
Name: slc3_mem_sequencer

Overview:
Memory access sequencer between the SLC-3 control unit's memory strobes (Mem_OE/Mem_WE, MAR, MDR) and the external asynchronous 16-bit SRAM. It converts level-held strobes into timed SRAM read and write cycles with programmable wait states. It returns a one-cycle Mem_Ready pulse and the read data, so the control unit no longer relies on hard-coded wait states. It optionally decodes one memory-mapped I/O address.

Parameters:
RD_WAIT, 2, cycles OE_N is held low before read data is sampled (legal 1..15)
WR_WAIT, 2, cycles WE_N is held low (legal 1..15)
ADDR_W, 20, SRAM address width (≥16)

Ports:
Clk  in  1  system clock, all flops rising-edge
Reset  in  1  asynchronous, active-high reset
Mem_OE  in  1  read request from control unit, level-held
Mem_WE  in  1  write request from control unit, level-held
MAR  in  16  access address
MDR  in  16  write data
Data_to_CPU  out  16  read data, valid from Mem_Ready until next read completes
Mem_Ready  out  1  one-cycle pulse: read data valid / write complete
SRAM_ADDR  out  ADDR_W  {zero-extend, latched MAR}
SRAM_CE_N  out  1  chip enable, active low
SRAM_OE_N  out  1  output enable, active low
SRAM_WE_N  out  1  write enable, active low
SRAM_UB_N  out  1  upper byte enable, active low
SRAM_LB_N  out  1  lower byte enable, active low
SRAM_Din  in  16  data from SRAM pins
SRAM_Dout  out  16  data to SRAM pins
SRAM_Drive  out  1  1 = tristate buffer drives SRAM_Dout onto DQ
Switches  in  16  board switches (MMIO only)
HEX_Data  out  16  hex display register (MMIO only)

Behaviour:
- Reset (async): state IDLE; CE_N/OE_N/WE_N/UB_N/LB_N=1; SRAM_Drive=0; Mem_Ready=0; Data_to_CPU=0; HEX_Data=0; wait counter=0. Asserting Reset mid-access releases all strobes immediately, with no completion pulse.
- States: IDLE, RD_ACC, RD_DONE, WR_SETUP, WR_ACC, WR_HOLD, RELEASE.
- IDLE: if Mem_WE=1, latch MAR and MDR and go to WR_SETUP. Write has priority when both strobes are high. Else if Mem_OE=1, latch MAR and go to RD_ACC. Else stay.
- RD_ACC: CE_N=0, OE_N=0, UB_N=LB_N=0 for RD_WAIT cycles. On the last cycle, register SRAM_Din into Data_to_CPU. Then go to RD_DONE.
- RD_DONE: Mem_Ready=1, strobes inactive, then go to RELEASE.
- Read latency: strobe sampled in IDLE at cycle 0; Mem_Ready at cycle RD_WAIT+1.
- WR_SETUP (1 cycle): CE_N=0, UB_N=LB_N=0, WE_N=1, SRAM_Drive=1.
- WR_ACC (WR_WAIT cycles): as WR_SETUP with WE_N=0.
- WR_HOLD (1 cycle): WE_N=1, CE_N=0, SRAM_Drive=1, Mem_Ready=1. Then go to RELEASE.
- Write latency: Mem_Ready at cycle WR_WAIT+2.
- OE_N and WE_N are never low in the same cycle. SRAM_Drive is never 1 while OE_N=0.
- RELEASE: strobes inactive; stay until Mem_OE=0 and Mem_WE=0, then go to IDLE. A held strobe therefore never triggers a second access.
- SRAM_ADDR and SRAM_Dout hold their latched values from accept until the next accept. Inputs changing mid-access are ignored.
- Wait counter: 4-bit, loaded with WAIT-1 on entry, decrements to 0. Out-of-range parameter values are an elaboration error.

Optional Feature:
Macro MEM_MMIO_EN.
- Defined:
  - Switches passes through a 2-flop synchronizer.
  - Accesses to MAR=16'hFFFF bypass SRAM; no SRAM strobe is asserted.
  - Read: IDLE→RD_DONE with Data_to_CPU=synchronized Switches (Mem_Ready at cycle 1).
  - Write: HEX_Data<=latched MDR, Mem_Ready at cycle 1, then RELEASE.
- Undefined: 16'hFFFF is ordinary SRAM; HEX_Data tied 0; Switches unused.

Test Plan:
- Reset asserted during RD_ACC → within the same cycle all SRAM strobes =1, SRAM_Drive=0; after release, state IDLE, no Mem_Ready pulse.
- RD_WAIT=2, SRAM model returns 16'h1234 at 16'h3000, Mem_OE held 5 cycles → OE_N low cycles 1–2, Mem_Ready single pulse cycle 3, Data_to_CPU=16'h1234, exactly one access.
- WR_WAIT=2, MAR=16'h0040, MDR=16'hBEEF, Mem_WE held → WR_SETUP cycle 1, WE_N low cycles 2–3, Mem_Ready cycle 4, SRAM_Drive 1–4; read-back gives 16'hBEEF; OE_N stays 1 throughout.
- Mem_OE=Mem_WE=1 simultaneously at MAR=16'h0001 → write sequence only; OE_N never asserted.
- Back-to-back reads 16'h0010 then 16'h0011 with strobe dropped one cycle between them → two Mem_Ready pulses with the correct data; no access while strobe is held after completion.
- MEM_MMIO_EN defined, Switches=16'h00A5, read 16'hFFFF → Mem_Ready cycle 1, Data_to_CPU=16'h00A5, CE_N stays 1. Write 16'h0F0F to 16'hFFFF → HEX_Data=16'h0F0F.
